// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: receive-only PS/2 device-to-host frame assembler.
// Synchronises the raw PS/2 clock and data lines and deglitches the clock.
// Decodes 11-bit frames (start, 8 data LSB-first, odd parity, stop).
// Each good byte is delivered with a one-cycle rx_valid strobe; framing,
// parity and timeout faults give a one-cycle rx_err strobe.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad parity.
// Without it the parity bit is consumed but ignored.
module ps2_rx_frame #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Odd parity holds when the data bits and the parity bit XOR to one.
  function automatic logic f_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   w_clk_s;
  logic                   w_dat_s;

  logic                   r_filt;
  logic [FCW-1:0]         r_fcnt;
  logic                   r_filt_d;
  logic                   r_fall;

  state_t                 r_state;
  logic [7:0]             r_shift;
  logic [2:0]             r_bit_cnt;
  logic [TCW-1:0]         r_tcnt;
  logic [7:0]             r_rx_data;
  logic                   r_rx_valid;
  logic                   r_rx_err;
  logic                   w_frame_ok;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

  // Metastability synchronisers for both lines; idle-high after reset.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_clk_sync <= {SYNC_STAGES{1'b1}};
      r_dat_sync <= {SYNC_STAGES{1'b1}};
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], PS2_DAT};
    end
  end

  // Clock deglitch: the filtered level follows only after FILTER_LEN
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_filt <= 1'b1;
      r_fcnt <= {FCW{1'b0}};
    end else if (w_clk_s == r_filt) begin
      r_fcnt <= {FCW{1'b0}};
    end else if (r_fcnt == FCW'(FILTER_LEN - 1)) begin
      r_filt <= w_clk_s;
      r_fcnt <= {FCW{1'b0}};
    end else begin
      r_fcnt <= r_fcnt + FCW'(1);
    end
  end

  // Registered one-cycle flag on each falling edge of the filtered clock.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_filt_d <= 1'b1;
      r_fall   <= 1'b0;
    end else begin
      r_filt_d <= r_filt;
      r_fall   <= r_filt_d & ~r_filt;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic r_par;

  // Holds the received parity bit until the stop bit is judged.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_par <= 1'b0;
    end else if (r_fall && (r_state == S_PARITY)) begin
      r_par <= w_dat_s;
    end else begin
      r_par <= r_par;
    end
  end

  assign w_frame_ok = w_dat_s & f_parity_ok(r_shift, r_par);
`else
  assign w_frame_ok = w_dat_s;
`endif

  // Frame FSM: steps on each fall flag; the timeout abandons stalled frames,
  // and a fall flag arriving in the same cycle as the timeout takes priority.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_shift    <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_tcnt     <= {TCW{1'b0}};
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      if (r_state == S_IDLE) begin
        r_tcnt <= {TCW{1'b0}};
        if (r_fall && !w_dat_s) begin
          r_state   <= S_DATA;
          r_bit_cnt <= 3'd0;
        end else begin
          r_state <= S_IDLE;
        end
      end else if (r_fall) begin
        r_tcnt <= {TCW{1'b0}};
        case (r_state)
          S_DATA: begin
            r_shift   <= {w_dat_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_PARITY;
            end else begin
              r_state <= S_DATA;
            end
          end
          S_PARITY: begin
            r_state <= S_STOP;
          end
          S_STOP: begin
            if (w_frame_ok) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_rx_err <= 1'b1;
            end
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end else if (r_tcnt == TCW'(TIMEOUT_CYC - 1)) begin
        r_rx_err <= 1'b1;
        r_state  <= S_IDLE;
        r_shift  <= 8'h00;
        r_tcnt   <= {TCW{1'b0}};
      end else begin
        r_tcnt <= r_tcnt + TCW'(1);
      end
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_err   = r_rx_err;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: the stimulus side pushes the expected
// strobe (kind, byte, arrival cycle) at each stop or abandoned frame; an
// independent negedge monitor pops and compares whenever a strobe appears.
module tb_ps2_rx_frame;

  localparam int SS   = 2;
  localparam int FL   = 8;
  localparam int TO   = 3000;
  localparam int LAT  = SS + FL + 2;
  localparam int HALF = 40;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       busy;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e_mon;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] model_data = 8'h00;
  bit         rst_chk = 1'b0;
  bit         final_chk = 1'b0;
  bit         final_done = 1'b0;

  ps2_rx_frame #(.SYNC_STAGES(SS), .FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .PS2_CLK (PS2_CLK),
    .PS2_DAT (PS2_DAT),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_err  (rx_err),
    .busy    (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // High phase with data presented, optional short low glitch, then the fall.
  task automatic fall_bit(input bit b, input bit glitch, output int fc);
    PS2_DAT = b;
    if (glitch) begin
      tick(15);
      PS2_CLK = 1'b0;
      tick(5);
      PS2_CLK = 1'b1;
      tick(HALF - 20);
    end else begin
      tick(HALF);
    end
    PS2_CLK = 1'b0;
    fc = cyc;
  endtask

  task automatic rise_bit();
    tick(HALF);
    PS2_CLK = 1'b1;
  endtask

  // Reference rule: odd parity, stop must be 1; parity matters only when checked.
  task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit stop, input bit glitch);
    logic [10:0] bits;
    logic        p;
    bit          ok;
    int          fc;
    p = ~(^d);
    if (flip_par) p = ~p;
`ifdef PS2_PARITY_CHECK_EN
    ok = stop && ((($countones(d) + int'(p)) % 2) == 1);
`else
    ok = stop;
`endif
    bits = {stop, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      fall_bit(bits[i], glitch && (i == 4), fc);
      if (i == 10) exp_q.push_back('{!ok, d, fc + LAT});
      rise_bit();
    end
  endtask

  // Start plus four data bits, then the clock stops: a timeout error is due.
  task automatic timeout_frame(input logic [7:0] d);
    logic [4:0] bits;
    int         fc;
    bits = {d[3:0], 1'b0};
    fc = 0;
    for (int i = 0; i < 5; i++) begin
      fall_bit(bits[i], 1'b0, fc);
      rise_bit();
    end
    exp_q.push_back('{1'b1, 8'h00, fc + LAT + TO});
    tick(TO + LAT + 40);
  endtask

  // Start plus three data bits, a one-cycle reset, then the rest of the frame
  // as all ones so nothing after the reset looks like a start bit.
  task automatic reset_frame(input logic [2:0] lo);
    logic [3:0] bits;
    int         fc;
    bits = {lo, 1'b0};
    for (int i = 0; i < 4; i++) begin
      fall_bit(bits[i], 1'b0, fc);
      rise_bit();
    end
    RESET_N = 1'b0;
    tick(1);
    RESET_N = 1'b1;
    for (int i = 0; i < 7; i++) begin
      fall_bit(1'b1, 1'b0, fc);
      rise_bit();
    end
  endtask

  // Monitor: reset-state check, strobe exclusivity and scoreboard compare.
  always @(negedge CLOCK_50) begin
    if (!RESET_N) begin
      model_data = 8'h00;
      rst_chk    = 1'b1;
    end else begin
      if (rst_chk) begin
        n_vec++;
        if (rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_err !== 1'b0 || busy !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_state: got data=%02h valid=%b err=%b busy=%b, want 00/0/0/0",
                   rx_data, rx_valid, rx_err, busy);
        end
        rst_chk = 1'b0;
      end
      if (rx_valid === 1'b1 && rx_err === 1'b1) begin
        n_vec++;
        n_bad++;
        $display("FAIL strobe_overlap: rx_valid and rx_err both high at cycle %0d", cyc);
      end else if (rx_valid === 1'b1 || rx_err === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_strobe: valid=%b err=%b data=%02h at cycle %0d, want none",
                   rx_valid, rx_err, rx_data, cyc);
        end else begin
          e_mon = exp_q.pop_front();
          if (rx_err !== e_mon.is_err || cyc != e_mon.cyc || busy !== 1'b0 ||
              rx_data !== (e_mon.is_err ? model_data : e_mon.data)) begin
            n_bad++;
            $display("FAIL strobe_check: got err=%b data=%02h cycle=%0d busy=%b, want err=%b data=%02h cycle=%0d busy=0",
                     rx_err, rx_data, cyc, busy, e_mon.is_err,
                     e_mon.is_err ? model_data : e_mon.data, e_mon.cyc);
          end
          if (!e_mon.is_err) model_data = e_mon.data;
        end
      end
      if (final_chk && !final_done) begin
        n_vec++;
        if (exp_q.size() != 0) begin
          n_bad++;
          $display("FAIL missing_strobe: %0d expected strobes never arrived, want 0", exp_q.size());
        end
        final_done = 1'b1;
      end
    end
  end

  initial begin
    RESET_N = 1'b0;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    tick(5);
    RESET_N = 1'b1;
    tick(20);

    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    tick(30);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    tick(30);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    tick(30);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    tick(30);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    tick(30);
    timeout_frame(8'hA5);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    tick(30);
    reset_frame(3'($urandom_range(0, 7)));
    tick(30);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      tick($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 40));
      send_frame(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0,
                 $urandom_range(0, 3) == 0);
    end

    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) tick(1);
    tick(5);
    final_chk = 1'b1;
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
